// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares the single vram access port between the video fetch path and a CPU
// req/ack requester. Video always wins the port and has a fixed read latency.
// The CPU side is a three-state FSM (IDLE, RDWAIT, DONE). A tag pipeline
// routes returning ram_q data to the right consumer.
// Optional feature macro: VRAM_ARB_STATS_EN adds a saturating CPU stall counter.
// When the macro is not defined, stall_count is tied to 0 and stats_clr is ignored.
module vram_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [15:0]       stall_count,
    input  logic              stats_clr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RDWAIT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              vid_grant;
    logic              cpu_grant;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Stage k of the tag pipeline is occupied in cycle T+1+k for an access
    // issued in cycle T; the last stage lines up with valid ram_q data.
    logic [RAM_LATENCY-1:0] vid_tag_q, vid_tag_d;
    logic [RAM_LATENCY-1:0] cpu_tag_q, cpu_tag_d;
    logic                   vid_exit;
    logic                   cpu_exit;

    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    assign vid_exit = vid_tag_q[RAM_LATENCY-1];
    assign cpu_exit = cpu_tag_q[RAM_LATENCY-1];

    // Port grant: video has absolute priority; the CPU may issue only from IDLE.
    always_comb begin
        vid_grant = vid_req;
        cpu_grant = 1'b0;
        if (!vid_req && (state_q == S_IDLE) && cpu_req) begin
            cpu_grant = 1'b1;
        end
    end

    // Drive the vram port from the grant; address holds when nobody issues.
    always_comb begin
        addr_d = addr_q;
        if (vid_grant) begin
            addr_d = vid_addr;
        end else if (cpu_grant) begin
            addr_d = cpu_addr;
        end
        ram_address = addr_d;
        ram_wren    = cpu_grant & cpu_we & ~reset;
        ram_data    = cpu_wdata;
    end

    // Shift issued reads down the tag pipeline.
    always_comb begin
        vid_tag_d    = '0;
        cpu_tag_d    = '0;
        vid_tag_d[0] = vid_grant;
        cpu_tag_d[0] = cpu_grant & ~cpu_we;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            vid_tag_d[i] = vid_tag_q[i-1];
            cpu_tag_d[i] = cpu_tag_q[i-1];
        end
    end

    // Capture returning read data for whichever requester owns the exiting tag.
    always_comb begin
        vid_valid_d = vid_exit;
        vid_data_d  = vid_exit ? ram_q : vid_data_q;
        cpu_rdata_d = cpu_exit ? ram_q : cpu_rdata_q;
    end

    // CPU FSM next state: writes ack in the following cycle, reads wait for data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_grant) begin
                    state_d = cpu_we ? S_DONE : S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (cpu_exit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All arbiter state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            vid_tag_q   <= '0;
            cpu_tag_q   <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            vid_tag_q   <= vid_tag_d;
            cpu_tag_q   <= cpu_tag_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_data_q;
    assign cpu_ack   = (state_q == S_DONE);
    assign cpu_rdata = cpu_rdata_q;

`ifdef VRAM_ARB_STATS_EN
    logic        cpu_denied;
    logic [15:0] stall_q, stall_d;

    assign cpu_denied = (state_q == S_IDLE) && cpu_req && vid_req;

    // Saturating count of cycles the CPU was refused the port; clear wins.
    always_comb begin
        stall_d = stall_q;
        if (stats_clr) begin
            stall_d = '0;
        end else if (cpu_denied && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign stall_count      = 16'd0;
`endif

endmodule
